// File: rtl/pattern_player_ctrl.sv
// pattern_player_ctrl: playback sequencer and upload arbiter for the pattern RAM.
// Optional bounce playback is built when PATTERN_PINGPONG_EN is defined.
module pattern_player_ctrl #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 72,
   parameter int HOLD_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              step,
   input  logic              run,
   input  logic              cfg_we,
   input  logic [1:0]        cfg_sel,
   input  logic [7:0]        cfg_data,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ack,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout,
   output logic [DATA_W-1:0] frame,
   output logic              frame_strobe,
   output logic [ADDR_W-1:0] play_addr
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_WRITE   = 2'd1;
   localparam logic [1:0] ST_FETCH   = 2'd2;
   localparam logic [1:0] ST_CAPTURE = 2'd3;

   localparam logic [1:0] SEL_START = 2'd0;
   localparam logic [1:0] SEL_END   = 2'd1;
   localparam logic [1:0] SEL_HOLD  = 2'd2;

   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic [ADDR_W-1:0] start_addr;
   logic [ADDR_W-1:0] end_addr;
   logic [ADDR_W-1:0] next_addr;
   logic [HOLD_W-1:0] hold;
   logic [HOLD_W-1:0] hold_cnt;
   logic              step_pend;
   logic              restart;
   logic              step_ev;
   logic              cfg_start;
   logic              svc_write;
   logic              svc_restart;
   logic              svc_step;
   logic              hold_hit;
   logic              advance;
   logic              count;

`ifdef PATTERN_PINGPONG_EN
   logic              bounce;
   logic              dir_down;
`endif

   assign step_ev   = step & run;
   assign cfg_start = cfg_we & (cfg_sel == SEL_START);
   assign hold_hit  = (hold_cnt >= hold);
   assign advance   = svc_step & hold_hit;
   assign count     = svc_step & ~hold_hit;

   // Service selection in IDLE: upload first, then restart refetch, then step.
   always_comb begin
      svc_write   = 1'b0;
      svc_restart = 1'b0;
      svc_step    = 1'b0;
      if (state == ST_IDLE) begin
         if (wr_req)
            svc_write = 1'b1;
         else if (restart)
            svc_restart = 1'b1;
         else if (run && (step_pend || step))
            svc_step = 1'b1;
      end
   end

   // Next playback address from loop bounds and direction.
   always_comb begin
      next_addr = play_addr + ADDR_W'(1);
      if (start_addr >= end_addr) begin
         next_addr = start_addr;
`ifdef PATTERN_PINGPONG_EN
      end else if (bounce && dir_down) begin
         if (play_addr <= start_addr)
            next_addr = start_addr + ADDR_W'(1);
         else
            next_addr = play_addr - ADDR_W'(1);
      end else if (bounce) begin
         if (play_addr >= end_addr)
            next_addr = end_addr - ADDR_W'(1);
`endif
      end else if (play_addr >= end_addr) begin
         next_addr = start_addr;
      end
   end

   // FSM transition logic.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (svc_write)
               state_nxt = ST_WRITE;
            else if (svc_restart || advance)
               state_nxt = ST_FETCH;
         end
         ST_WRITE:   state_nxt = ST_IDLE;
         ST_FETCH:   state_nxt = ST_CAPTURE;
         ST_CAPTURE: state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // Loop bounds and hold count registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         start_addr <= '0;
         end_addr   <= '1;
         hold       <= '0;
      end else if (cfg_we) begin
         case (cfg_sel)
            SEL_START: start_addr <= ADDR_W'(cfg_data);
            SEL_END:   end_addr   <= ADDR_W'(cfg_data);
            SEL_HOLD:  hold       <= HOLD_W'(cfg_data);
            default:   ;
         endcase
      end
   end

`ifdef PATTERN_PINGPONG_EN
   // Bounce enable bit of the mode register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         bounce <= 1'b0;
      else if (cfg_we && cfg_sel == 2'd3)
         bounce <= cfg_data[0];
   end

   // Direction flips when an advance turns around at either bound.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dir_down <= 1'b0;
      end else if (cfg_start) begin
         dir_down <= 1'b0;
      end else if (advance && bounce && start_addr < end_addr) begin
         if (!dir_down && play_addr >= end_addr)
            dir_down <= 1'b1;
         else if (dir_down && play_addr <= start_addr)
            dir_down <= 1'b0;
      end
   end
`endif

   // One-deep step latch; a start write forces a refetch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         step_pend <= 1'b1;
      else if (cfg_start)
         step_pend <= 1'b1;
      else if (svc_restart)
         step_pend <= step_ev;
      else if (svc_step)
         step_pend <= 1'b0;
      else if (step_ev)
         step_pend <= 1'b1;
   end

   // Restart flag: refetch current start address without advancing.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         restart <= 1'b1;
      else if (cfg_start)
         restart <= 1'b1;
      else if (svc_restart)
         restart <= 1'b0;
   end

   // Playback address.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         play_addr <= '0;
      else if (cfg_start)
         play_addr <= ADDR_W'(cfg_data);
      else if (advance)
         play_addr <= next_addr;
   end

   // Frame hold counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         hold_cnt <= '0;
      else if (cfg_start || svc_restart || advance)
         hold_cnt <= '0;
      else if (count)
         hold_cnt <= hold_cnt + HOLD_W'(1);
   end

   // Capture the fetched word and flag it visible the next cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame        <= '0;
         frame_strobe <= 1'b0;
      end else begin
         frame_strobe <= (state == ST_CAPTURE);
         if (state == ST_CAPTURE)
            frame <= ram_dout;
      end
   end

   assign ram_we   = (state == ST_WRITE);
   assign wr_ack   = (state == ST_WRITE);
   assign ram_addr = (state == ST_WRITE) ? wr_addr : play_addr;
   assign ram_din  = wr_data;

endmodule

// File: tb/tb_pattern_player_ctrl.sv
// tb_pattern_player_ctrl: randomized bench for pattern_player_ctrl with a
// behavioural RAM and a playback reference model.
module tb_pattern_player_ctrl;

  localparam int AW = 8;
  localparam int DW = 72;
  localparam int HW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          step = 1'b0;
  logic          run = 1'b1;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_sel = '0;
  logic [7:0]    cfg_data = '0;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ack;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic [DW-1:0] frame;
  logic          frame_strobe;
  logic [AW-1:0] play_addr;

  int total = 0;
  int bad = 0;

  logic [DW-1:0] mem [256];
  logic [DW-1:0] mm [256];
  logic          fill = 1'b0;

  int            m_start, m_end, m_hold, m_mode, m_pa, m_hc;
  bit            m_down;
  logic [DW-1:0] m_frame;

  pattern_player_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .HOLD_W(HW)
  ) dut (
    .clk(clk), .rst(rst), .step(step), .run(run),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_data(cfg_data),
    .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wr_ack(wr_ack), .ram_addr(ram_addr),
    .ram_we(ram_we),
    .ram_din(ram_din), .ram_dout(ram_dout),
    .frame(frame),
    .frame_strobe(frame_strobe),
    .play_addr(play_addr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 256; i++) mem[i] <= mm[i];
    end else if (ram_we) begin
      mem[ram_addr] <= ram_din;
    end
    ram_dout <= mem[ram_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rnd_word();
    return DW'({$urandom(), $urandom(), $urandom()});
  endfunction

  function automatic bit bounce_on();
`ifdef PATTERN_PINGPONG_EN
    return (m_mode & 1) != 0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic m_reset();
    m_start = 0; m_end = 255; m_hold = 0; m_mode = 0;
    m_pa = 0; m_hc = 0; m_down = 0;
  endtask

  task automatic m_advance();
    if (m_start >= m_end) begin
      m_pa = m_start;
    end else if (bounce_on()) begin
      if (!m_down) begin
        if (m_pa >= m_end) begin
          m_down = 1; m_pa = m_end - 1;
        end else m_pa = m_pa + 1;
      end else begin
        if (m_pa <= m_start) begin
          m_down = 0; m_pa = m_start + 1;
        end else m_pa = m_pa - 1;
      end
    end else begin
      m_pa = (m_pa >= m_end) ? m_start : m_pa + 1;
    end
  endtask

  task automatic m_step(output bit changed);
    if (m_hc < m_hold) begin
      m_hc++;
      changed = 0;
    end else begin
      m_hc = 0;
      m_advance();
      changed = 1;
    end
  endtask

  task automatic cfg(input logic [1:0] sel,
                     input logic [7:0] d);
    cfg_sel = sel; cfg_data = d; cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
    case (sel)
      2'd0: begin
        m_start = d; m_pa = d; m_hc = 0; m_down = 0;
        tick(); tick(); tick();
        total++;
        if ({frame_strobe, play_addr, frame} !==
            {1'b1, AW'(m_pa), mm[m_pa]}) begin
          bad++;
          $display("FAIL restart_fetch got s=%b a=%0d f=%h want s=1 a=%0d f=%h",
                   frame_strobe, play_addr, frame, m_pa, mm[m_pa]);
        end
        m_frame = mm[m_pa];
      end
      2'd1: m_end = d;
      2'd2: m_hold = d;
      default: m_mode = d;
    endcase
    tick();
  endtask

  task automatic do_step();
    bit ch;
    step = 1'b1;
    tick();
    step = 1'b0;
    m_step(ch);
    if (ch) begin
      tick();
      total++;
      if (frame_strobe !== 1'b0) begin
        bad++;
        $display("FAIL early_strobe got %b want 0", frame_strobe);
      end
      tick();
      total++;
      if ({frame_strobe, play_addr, frame} !==
          {1'b1, AW'(m_pa), mm[m_pa]}) begin
        bad++;
        $display("FAIL step_frame got s=%b a=%0d f=%h want s=1 a=%0d f=%h",
                 frame_strobe, play_addr, frame, m_pa, mm[m_pa]);
      end
      m_frame = mm[m_pa];
    end else begin
      for (int k = 0; k < 3; k++) begin
        total++;
        if ({frame_strobe, play_addr, frame} !==
            {1'b0, AW'(m_pa), m_frame}) begin
          bad++;
          $display("FAIL held_frame got s=%b a=%0d f=%h want s=0 a=%0d f=%h",
                   frame_strobe, play_addr, frame, m_pa, m_frame);
        end
        if (k < 2) tick();
      end
    end
    tick();
  endtask

  task automatic write_word(input int a,
                            input logic [DW-1:0] d,
                            input int exp_lat);
    int lat;
    lat = 0;
    wr_req = 1'b1; wr_addr = AW'(a); wr_data = d;
    do begin
      tick();
      lat++;
    end while (wr_ack !== 1'b1 && lat < 20);
    wr_req = 1'b0;
    total++;
    if (wr_ack !== 1'b1 || lat != exp_lat) begin
      bad++;
      $display("FAIL write_ack got ack=%b lat=%0d want ack=1 lat=%0d",
               wr_ack, lat, exp_lat);
    end
    mm[a] = d;
    tick();
  endtask

  task automatic test_reset();
    total++;
    if ({frame, frame_strobe, wr_ack, ram_we,
         ram_addr, play_addr} !== '0) begin
      bad++;
      $display("FAIL reset_state got f=%h s=%b ack=%b we=%b ra=%0d pa=%0d want all 0",
               frame, frame_strobe, wr_ack, ram_we, ram_addr, play_addr);
    end
    rst = 1'b0;
    m_reset();
    tick(); tick();
    total++;
    if (frame_strobe !== 1'b0) begin
      bad++;
      $display("FAIL reset_early_strobe got %b want 0", frame_strobe);
    end
    tick();
    total++;
    if ({frame_strobe, play_addr, frame} !==
        {1'b1, 8'd0, mm[0]}) begin
      bad++;
      $display("FAIL reset_fetch got s=%b a=%0d f=%h want s=1 a=0 f=%h",
               frame_strobe, play_addr, frame, mm[0]);
    end
    m_frame = mm[0];
    tick();
  endtask

  task automatic test_wrap();
    int exp_a [5];
    exp_a = '{1, 2, 3, 0, 1};
    cfg(2'd1, 8'd3);
    cfg(2'd2, 8'd0);
    cfg(2'd0, 8'd0);
    for (int i = 0; i < 5; i++) begin
      do_step();
      total++;
      if (play_addr !== AW'(exp_a[i])) begin
        bad++;
        $display("FAIL wrap_seq[%0d] got %0d want %0d",
                 i, play_addr, exp_a[i]);
      end
    end
  endtask

  task automatic test_hold();
    cfg(2'd2, 8'd2);
    for (int i = 0; i < 9; i++) do_step();
    cfg(2'd2, 8'd0);
  endtask

  task automatic test_step_and_write();
    logic [DW-1:0] d;
    d = 72'hA5A5_A5A5_A5A5_A5A5_A5;
    cfg(2'd1, 8'd7);
    cfg(2'd0, 8'd4);
    step = 1'b1; wr_req = 1'b1;
    wr_addr = 8'd5; wr_data = d;
    tick();
    step = 1'b0;
    total++;
    if ({wr_ack, ram_we, ram_addr} !==
        {1'b1, 1'b1, 8'd5}) begin
      bad++;
      $display("FAIL collide_ack got ack=%b we=%b ra=%0d want 1 1 5",
               wr_ack, ram_we, ram_addr);
    end
    wr_req = 1'b0;
    mm[5] = d;
    m_pa = 5;
    tick();
    total++;
    if ({wr_ack, frame_strobe} !== 2'b00) begin
      bad++;
      $display("FAIL collide_idle got ack=%b s=%b want 0 0",
               wr_ack, frame_strobe);
    end
    tick(); tick(); tick();
    total++;
    if ({frame_strobe, play_addr, frame} !==
        {1'b1, 8'd5, d}) begin
      bad++;
      $display("FAIL collide_fetch got s=%b a=%0d f=%h want s=1 a=5 f=%h",
               frame_strobe, play_addr, frame, d);
    end
    m_frame = d;
    tick();
  endtask

  task automatic test_write_in_fetch();
    logic [DW-1:0] old, d;
    step = 1'b1;
    tick();
    step = 1'b0;
    m_advance();
    old = mm[m_pa];
    d = rnd_word();
    wr_req = 1'b1; wr_addr = AW'(m_pa); wr_data = d;
    tick();
    total++;
    if (wr_ack !== 1'b0) begin
      bad++;
      $display("FAIL fetch_no_ack got %b want 0", wr_ack);
    end
    tick();
    total++;
    if ({wr_ack, frame_strobe, frame} !==
        {1'b0, 1'b1, old}) begin
      bad++;
      $display("FAIL fetch_frame got ack=%b s=%b f=%h want 0 1 %h",
               wr_ack, frame_strobe, frame, old);
    end
    tick();
    total++;
    if (wr_ack !== 1'b1) begin
      bad++;
      $display("FAIL fetch_late_ack got %b want 1", wr_ack);
    end
    wr_req = 1'b0;
    mm[m_pa] = d;
    m_frame = old;
    tick();
    total++;
    if ({frame_strobe, frame} !== {1'b0, old}) begin
      bad++;
      $display("FAIL no_snoop got s=%b f=%h want 0 %h",
               frame_strobe, frame, old);
    end
    tick();
  endtask

  task automatic test_run_pause();
    int a;
    run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      tick(); tick();
      total++;
      if ({frame_strobe, play_addr, frame} !==
          {1'b0, AW'(m_pa), m_frame}) begin
        bad++;
        $display("FAIL paused[%0d] got s=%b a=%0d f=%h want 0 %0d %h",
                 i, frame_strobe, play_addr, frame, m_pa, m_frame);
      end
    end
    a = (m_pa + 100) % 256;
    write_word(a, rnd_word(), 1);
    run = 1'b1;
    do_step();
  endtask

  task automatic test_pingpong();
    int exp_a [5];
`ifdef PATTERN_PINGPONG_EN
    exp_a = '{3, 4, 3, 2, 3};
`else
    exp_a = '{3, 4, 2, 3, 4};
`endif
    cfg(2'd3, 8'd1);
    cfg(2'd1, 8'd4);
    cfg(2'd0, 8'd2);
    for (int i = 0; i < 5; i++) begin
      do_step();
      total++;
      if (play_addr !== AW'(exp_a[i])) begin
        bad++;
        $display("FAIL bounce_seq[%0d] got %0d want %0d",
                 i, play_addr, exp_a[i]);
      end
    end
    cfg(2'd3, 8'd0);
  endtask

  task automatic test_reset_mid();
    int a;
    a = (m_pa + 37) % 256;
    wr_req = 1'b1; wr_addr = AW'(a); wr_data = ~mm[a];
    tick();
    rst = 1'b1;
    #1;
    total++;
    if ({wr_ack, ram_we, frame, frame_strobe,
         play_addr, ram_addr} !== '0) begin
      bad++;
      $display("FAIL mid_reset got ack=%b we=%b f=%h s=%b pa=%0d ra=%0d want 0",
               wr_ack, ram_we, frame, frame_strobe, play_addr, ram_addr);
    end
    wr_req = 1'b0;
    tick();
    total++;
    if (mem[a] !== mm[a]) begin
      bad++;
      $display("FAIL lost_write got %h want %h", mem[a], mm[a]);
    end
    rst = 1'b0;
    m_reset();
    tick(); tick(); tick();
    total++;
    if ({frame_strobe, play_addr, frame} !==
        {1'b1, 8'd0, mm[0]}) begin
      bad++;
      $display("FAIL mid_reset_fetch got s=%b a=%0d f=%h want 1 0 %h",
               frame_strobe, play_addr, frame, mm[0]);
    end
    m_frame = mm[0];
    tick();
  endtask

  task automatic test_random();
    int op, s, a;
    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 9);
      case (op)
        0: cfg(2'd2, 8'($urandom_range(0, 2)));
        1: cfg(2'd1, 8'($urandom_range(0, 255)));
        2: begin
          s = $urandom_range(0, 250);
          cfg(2'd1, 8'(s + $urandom_range(0, 5)));
          cfg(2'd0, 8'(s));
        end
        3: cfg(2'd3, 8'($urandom_range(0, 3)));
        4, 5: begin
          a = ($urandom_range(0, 1) == 0) ?
              m_pa : $urandom_range(0, 255);
          write_word(a, rnd_word(), 1);
        end
        default: do_step();
      endcase
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) mm[i] = rnd_word();
    fill = 1'b1;
    tick();
    fill = 1'b0;
    tick();
    test_reset();
    test_wrap();
    test_hold();
    test_step_and_write();
    test_write_in_fetch();
    test_run_pause();
    test_pingpong();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
